// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared types and default widths for the pipeline stage
//                register: the three-state occupancy enum, the default
//                payload and control widths, the ID/EX payload width and
//                an occupancy decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

   localparam int PIPE_DATA_W = 32;
   localparam int PIPE_CTRL_W = 8;

   // ID/EX payload: pc + rs1 value + rs1/rs2/rd indices + immediate
   localparam int IDEX_DATA_W = 32 + 32 + 5 + 5 + 5 + 32;
   localparam int IDEX_CTRL_W = 8;

   // Encoding doubles as the item count held by the stage
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } pipe_state_t;

   function automatic logic [1:0] occ_of(input pipe_state_t s);
      case (s)
         ST_FULL: return 2'd1;
         ST_SKID: return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_slot
//  Description : One storage slot (valid + ctrl + data) with load and a
//                synchronous clear. Loading an invalid item drops valid and
//                zeroes ctrl but leaves the payload as it was.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int DATA_W        = PIPE_DATA_W,
   parameter int CTRL_W        = PIPE_CTRL_W,
   parameter int CLR_ZERO_DATA = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              load,
   input  logic              d_valid,
   input  logic [DATA_W-1:0] d_data,
   input  logic [CTRL_W-1:0] d_ctrl,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic [CTRL_W-1:0] ctrl
);

   // Slot register: clear beats load; ctrl is never non-zero without valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
         ctrl  <= '0;
      end else if (clr) begin
         valid <= 1'b0;
         ctrl  <= '0;
         if (CLR_ZERO_DATA != 0) data <= '0;
      end else if (load) begin
         valid <= d_valid;
         ctrl  <= d_valid ? d_ctrl : '0;
         if (d_valid) data <= d_data;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Valid/ready pipeline stage register with flush (clr).
//                Main slot drives out_*; with PIPE_STAGE_SKID_EN defined a
//                skid slot absorbs one item so in_ready is a pure register
//                output. Without the macro there is no skid slot and
//                in_ready = !out_valid | out_ready.
//  Config      : `define PIPE_STAGE_SKID_EN to enable the skid slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W        = PIPE_DATA_W,
   parameter int CTRL_W        = PIPE_CTRL_W,
   parameter int CLR_ZERO_DATA = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occ
);

   pipe_state_t       state, state_nx;
   logic              accept, consume;
   logic              main_load, main_d_valid;
   logic [DATA_W-1:0] main_d_data;
   logic [CTRL_W-1:0] main_d_ctrl;

   assign accept  = in_valid & in_ready;
   assign consume = out_valid & out_ready;
   assign occ     = occ_of(state);

`ifdef PIPE_STAGE_SKID_EN
   logic              main_from_skid;
   logic              skid_load, skid_d_valid;
   logic              skid_valid;
   logic [DATA_W-1:0] skid_data;
   logic [CTRL_W-1:0] skid_ctrl;
   logic              ready_q;

   assign in_ready    = ready_q;
   assign main_d_data = main_from_skid ? skid_data : in_data;
   assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;

   // in_ready registered from the next state so out_ready never reaches it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ready_q <= 1'b1;
      else        ready_q <= (state_nx != ST_SKID);
   end

   pipe_slot #(
      .DATA_W        (DATA_W),
      .CTRL_W        (CTRL_W),
      .CLR_ZERO_DATA (CLR_ZERO_DATA)
   ) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .load    (skid_load),
      .d_valid (skid_d_valid),
      .d_data  (in_data),
      .d_ctrl  (in_ctrl),
      .valid   (skid_valid),
      .data    (skid_data),
      .ctrl    (skid_ctrl)
   );
`else
   assign in_ready    = ~out_valid | out_ready;
   assign main_d_data = in_data;
   assign main_d_ctrl = in_ctrl;
`endif

   // Occupancy state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_EMPTY;
      else        state <= state_nx;
   end

   // Next state and slot load controls; clr forces EMPTY (slots clear themselves)
   always_comb begin
      state_nx     = state;
      main_load    = 1'b0;
      main_d_valid = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      skid_d_valid   = 1'b0;
`endif
      case (state)
         ST_EMPTY: begin
            if (accept) begin
               state_nx     = ST_FULL;
               main_load    = 1'b1;
               main_d_valid = 1'b1;
            end
         end
         ST_FULL: begin
            if (accept && consume) begin
               main_load    = 1'b1;
               main_d_valid = 1'b1;
            end else if (consume) begin
               state_nx     = ST_EMPTY;
               main_load    = 1'b1;
               main_d_valid = 1'b0;
            end
`ifdef PIPE_STAGE_SKID_EN
            else if (accept) begin
               state_nx     = ST_SKID;
               skid_load    = 1'b1;
               skid_d_valid = 1'b1;
            end
`endif
         end
`ifdef PIPE_STAGE_SKID_EN
         ST_SKID: begin
            if (consume) begin
               state_nx       = ST_FULL;
               main_load      = 1'b1;
               main_from_skid = 1'b1;
               main_d_valid   = skid_valid;
               skid_load      = 1'b1;
               skid_d_valid   = 1'b0;
            end
         end
`endif
         default: state_nx = ST_EMPTY;
      endcase
      if (clr) state_nx = ST_EMPTY;
   end

   pipe_slot #(
      .DATA_W        (DATA_W),
      .CTRL_W        (CTRL_W),
      .CLR_ZERO_DATA (CLR_ZERO_DATA)
   ) u_main (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .load    (main_load),
      .d_valid (main_d_valid),
      .d_data  (main_d_data),
      .d_ctrl  (main_d_ctrl),
      .valid   (out_valid),
      .data    (out_data),
      .ctrl    (out_ctrl)
   );

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32: operand/payload width carried through the stage.
REQ-002 Parameter CTRL_W, default 8: control-bit width (RegWrite, MemWrite, ALU control, and similar); always zeroed on flush.
REQ-003 Parameter CLR_ZERO_DATA, default 1: 1 = payload zeroed on flush; 0 = payload held and only valid/ctrl cleared.
REQ-004 CLK  in  1  single clock; all state updates on the rising edge.
REQ-005 Reset  in  1  asynchronous, active-low reset.
REQ-006 CLR  in  1  synchronous flush (bubble insert), active-high.
REQ-007 in_valid  in  1  upstream holds a valid item.
REQ-008 in_ready  out  1  stage accepts an item this cycle.
REQ-009 in_data  in  DATA_W  upstream payload.
REQ-010 in_ctrl  in  CTRL_W  upstream control bits.
REQ-011 out_valid  out  1  stage presents a valid item.
REQ-012 out_ready  in  1  downstream accepts this cycle.
REQ-013 out_data  out  DATA_W  presented payload.
REQ-014 out_ctrl  out  CTRL_W  presented control bits; all-zero whenever out_valid=0.
REQ-015 occ  out  2  item count held (0..2).

Function
REQ-016 Transfer rule: input accepted iff in_valid & in_ready; output consumed iff out_valid & out_ready.
REQ-017 Storage: main register (drives out_*) plus one skid register; FSM states EMPTY (occ=0), FULL (occ=1), SKID (occ=2).
REQ-018 in_ready is a direct register output: in_ready = (state != SKID); no combinational path from out_ready.
REQ-019 EMPTY + accept -> FULL; item appears on out_* the next cycle (latency 1).
REQ-020 FULL + accept + consume -> FULL with new item in main (full throughput, 1 item/cycle).
REQ-021 FULL + consume, no accept -> EMPTY.
REQ-022 FULL + accept, no consume -> SKID; new item goes to the skid register; main is unchanged.
REQ-023 SKID + consume -> FULL; skid moves to main the next cycle. SKID + no consume -> SKID, all contents held.
REQ-024 Ordering is strictly FIFO; no item is dropped or duplicated except by CLR.
REQ-025 CLR=1 overrides every transfer that cycle: next state EMPTY, both valids 0, ctrl zeroed, payload zeroed iff CLR_ZERO_DATA=1.
REQ-026 CLR=1: any same-cycle input handshake is discarded; in_ready=1 on the following cycle.
REQ-027 out_data/out_ctrl are stable while out_valid=1 and out_ready=0.

Reset
REQ-028 Reset low asynchronously forces: state EMPTY, occ=0, out_valid=0, out_data=0, out_ctrl=0, skid contents=0, in_ready=1.
REQ-029 Reset asserted mid-transfer discards all held items; the first accept after deassertion behaves as from EMPTY.
REQ-030 Reset takes priority over CLR.

Configuration
REQ-031 Macro PIPE_STAGE_SKID_EN defined: skid register and SKID state are present, and REQ-017..REQ-023 apply.
REQ-032 Macro PIPE_STAGE_SKID_EN undefined: no skid register; occ is never greater than 1; in_ready = !out_valid | out_ready (combinational); FULL + accept with no consume cannot occur; all other rules are unchanged.

Structure
REQ-033 A shared package pipe_pkg holds the state enum (EMPTY/FULL/SKID) and default-width constants PIPE_DATA_W=32 and PIPE_CTRL_W=8.
REQ-034 One sub-module, pipe_slot, is natural: a valid+ctrl+data register with load and clear; it is instantiated as main and as skid.
REQ-035 The ID/EX register is an instance with DATA_W = 32+32+5+5+5+32 = 111 and CTRL_W = 8.

Verification
REQ-036 Reset low, in_valid=1, in_data=0xA5 -> out_valid=0, occ=0, in_ready=1; after release, accept on the first edge -> out_data=0xA5 on the next cycle.
REQ-037 out_ready=1, stream 0x1,0x2,0x3 back-to-back -> out_data=0x1,0x2,0x3 on consecutive cycles, occ stays 1.
REQ-038 Stall (SKID_EN): out_ready=0, send 0x10,0x20 -> occ=2, in_ready=0, out_data=0x10; raise out_ready -> 0x10 then 0x20, occ 2->1->0.
REQ-039 CLR=1 with occ=2 and in_valid=1, in_ctrl=0xFF -> next cycle occ=0, out_valid=0, out_ctrl=0x00, out_data=0 (CLR_ZERO_DATA=1) or held (CLR_ZERO_DATA=0).
REQ-040 Randomised in_valid/out_ready for 10k cycles against a scoreboard FIFO -> no loss or reorder; out_* stable under stall; repeated with PIPE_STAGE_SKID_EN undefined.
